figure_renderer: RTL and testbench



---
 rtl/fig_pkg.sv | 28 ++
 rtl/rect_hit.sv | 27 ++
 rtl/figure_renderer.sv | 147 ++++++++++++++
 tb/tb_figure_renderer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fig_pkg.sv
// Shared field codes, widths and the rectangle record for figure_renderer.
package fig_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 3;

    typedef enum logic [2:0] {
        FLD_XL    = 3'd0,
        FLD_YT    = 3'd1,
        FLD_W     = 3'd2,
        FLD_H     = 3'd3,
        FLD_COLOR = 3'd4,
        FLD_EN    = 3'd5,
        FLD_BLINK = 3'd6,
        FLD_NONE  = 3'd7
    } field_t;

    typedef struct packed {
        logic [COORD_W-1:0] x_l;
        logic [COORD_W-1:0] y_t;
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
        logic [COLOR_W-1:0] color;
        logic               enable;
        logic               blink;
    } rect_t;

endpackage

// File: rtl/rect_hit.sv
// Point-in-rectangle test for one rectangle; right/bottom edges use 11-bit sums
// so a rectangle running past column/line 1023 never wraps back to 0.
module rect_hit
    import fig_pkg::*;
(
    input  logic [COORD_W-1:0] x_l,
    input  logic [COORD_W-1:0] y_t,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic               enable,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    output logic               hit
);

    logic [COORD_W:0] x_r;
    logic [COORD_W:0] y_b;

    always_comb begin
        x_r = {1'b0, x_l} + {1'b0, width};
        y_b = {1'b0, y_t} + {1'b0, height};
        hit = enable
            && (hcount >= x_l) && ({1'b0, hcount} < x_r)
            && (vcount >= y_t) && ({1'b0, vcount} < y_b);
    end

endmodule

// File: rtl/figure_renderer.sv
// Renders N_RECT programmable filled rectangles over BG_COLOR with a 2-pixel pipeline.
// Optional blinking rectangles are enabled with the FIG_BLINK_EN macro.
module figure_renderer
    import fig_pkg::*;
#(
    parameter int                 N_RECT     = 4,
    parameter int                 IDX_W      = 2,
    parameter int                 H_ACTIVE   = 640,
    parameter int                 V_ACTIVE   = 480,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 3'b110,
    parameter int                 BLINK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               px_en,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               video_on,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [2:0]         wr_field,
    input  logic [COORD_W-1:0] wr_data,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

    if (N_RECT < 1 || N_RECT > 16 || (1 << IDX_W) < N_RECT || BLINK_LOG2 < 0) begin : g_bad_cfg
        $error("figure_renderer: invalid parameter set");
    end

    rect_t              shadow [N_RECT];
    rect_t              active [N_RECT];
    logic [N_RECT-1:0]  hit_raw;
    logic [N_RECT-1:0]  hit_vec;
    logic [N_RECT-1:0]  hit_d;
    logic               video_on_d;
    logic               commit;
    logic               in_area;
    logic               blink_phase;
    logic [COLOR_W-1:0] pick;

    assign commit  = px_en && (hcount == '0) && (vcount == V_LIM);
    assign in_area = (hcount < H_LIM) && (vcount < V_LIM);

    // Commit copies the pre-write shadow; a same-cycle write lands in shadow only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_RECT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (commit) begin
                for (int unsigned i = 0; i < N_RECT; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_en) begin
                for (int unsigned i = 0; i < N_RECT; i++) begin
                    if (wr_idx == IDX_W'(i)) begin
                        case (wr_field)
                            FLD_XL:    shadow[i].x_l    <= wr_data;
                            FLD_YT:    shadow[i].y_t    <= wr_data;
                            FLD_W:     shadow[i].width  <= wr_data;
                            FLD_H:     shadow[i].height <= wr_data;
                            FLD_COLOR: shadow[i].color  <= wr_data[COLOR_W-1:0];
                            FLD_EN:    shadow[i].enable <= wr_data[0];
`ifdef FIG_BLINK_EN
                            FLD_BLINK: shadow[i].blink  <= wr_data[0];
`endif
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

`ifdef FIG_BLINK_EN
    logic [BLINK_LOG2:0] frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (commit) begin
            frame_cnt <= frame_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
        end
    end

    assign blink_phase = frame_cnt[BLINK_LOG2];
`else
    assign blink_phase = 1'b0;
`endif

    for (genvar g = 0; g < N_RECT; g++) begin : g_rect
        rect_hit u_hit (
            .x_l    (active[g].x_l),
            .y_t    (active[g].y_t),
            .width  (active[g].width),
            .height (active[g].height),
            .enable (active[g].enable),
            .hcount (hcount),
            .vcount (vcount),
            .hit    (hit_raw[g])
        );
    end

    always_comb begin
        hit_vec = '0;
        for (int unsigned i = 0; i < N_RECT; i++) begin
            hit_vec[i] = hit_raw[i] && in_area && !(active[i].blink && blink_phase);
        end
    end

    // Lowest index wins: first set bit found while scanning upward.
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = BG_COLOR;
        for (int unsigned i = 0; i < N_RECT; i++) begin
            if (hit_d[i] && !found) begin
                pick  = active[i].color;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_d       <= '0;
            video_on_d  <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= commit;
            if (px_en) begin
                hit_d      <= hit_vec;
                video_on_d <= video_on;
                rgb        <= video_on_d ? pick : '0;
            end
        end
    end

endmodule

// File: tb/tb_figure_renderer.sv
// Directed plus randomized checks of figure_renderer against an arithmetic reference model.
module tb_figure_renderer;

    localparam int NR = 3;
`ifdef FIG_BLINK_EN
    localparam int BL = 1;
`else
    localparam int BL = 5;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       px_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       video_on;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [2:0] wr_field;
    logic [9:0] wr_data;
    logic [2:0] rgb;
    logic       frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: shadow and active rectangle sets plus commit count.
    int s_x[NR], s_y[NR], s_w[NR], s_h[NR], s_c[NR], s_en[NR], s_bl[NR];
    int a_x[NR], a_y[NR], a_w[NR], a_h[NR], a_c[NR], a_en[NR], a_bl[NR];
    int n_commit = 0;

    figure_renderer #(
        .N_RECT     (NR),
        .IDX_W      (2),
        .H_ACTIVE   (640),
        .V_ACTIVE   (480),
        .BG_COLOR   (3'b110),
        .BLINK_LOG2 (BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .px_en       (px_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .video_on    (video_on),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_field    (wr_field),
        .wr_data     (wr_data),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, int obs, int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            s_x[i] = 0; s_y[i] = 0; s_w[i] = 0; s_h[i] = 0; s_c[i] = 0; s_en[i] = 0; s_bl[i] = 0;
            a_x[i] = 0; a_y[i] = 0; a_w[i] = 0; a_h[i] = 0; a_c[i] = 0; a_en[i] = 0; a_bl[i] = 0;
        end
        n_commit = 0;
    endfunction

    function automatic void model_wr(int idx, int fld, int data);
        if (idx >= NR) return;
        case (fld)
            0: s_x[idx]  = data;
            1: s_y[idx]  = data;
            2: s_w[idx]  = data;
            3: s_h[idx]  = data;
            4: s_c[idx]  = data % 8;
            5: s_en[idx] = data % 2;
`ifdef FIG_BLINK_EN
            6: s_bl[idx] = data % 2;
`endif
            default: ;
        endcase
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < NR; i++) begin
            a_x[i] = s_x[i]; a_y[i] = s_y[i]; a_w[i] = s_w[i]; a_h[i] = s_h[i];
            a_c[i] = s_c[i]; a_en[i] = s_en[i]; a_bl[i] = s_bl[i];
        end
        n_commit++;
    endfunction

    function automatic int model_px(int h, int v, int von);
        int hidden;
`ifdef FIG_BLINK_EN
        hidden = (n_commit % (2 ** (BL + 1))) >= (2 ** BL) ? 1 : 0;
`else
        hidden = 0;
`endif
        if (von == 0) return 0;
        if (h >= 640 || v >= 480) return 6;
        for (int i = 0; i < NR; i++) begin
            if (a_en[i] == 1 && !(a_bl[i] == 1 && hidden == 1)
                && h >= a_x[i] && h < a_x[i] + a_w[i]
                && v >= a_y[i] && v < a_y[i] + a_h[i])
                return a_c[i];
        end
        return 6;
    endfunction

    task automatic wr(int idx, int fld, int data);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_field = 3'(fld); wr_data = 10'(data);
        tick();
        wr_en = 1'b0;
        model_wr(idx, fld, data);
    endtask

    task automatic wr_rect(int idx, int x, int y, int w, int h, int c, int en);
        wr(idx, 0, x); wr(idx, 1, y); wr(idx, 2, w); wr(idx, 3, h); wr(idx, 4, c); wr(idx, 5, en);
    endtask

    // Commit pixel, optionally with a register write in the same clock.
    task automatic do_commit(int with_wr, int idx, int fld, int data);
        hcount = 10'd0; vcount = 10'd480; video_on = 1'b0; px_en = 1'b1;
        if (with_wr != 0) begin
            wr_en = 1'b1; wr_idx = 2'(idx); wr_field = 3'(fld); wr_data = 10'(data);
        end
        tick();
        px_en = 1'b0; wr_en = 1'b0;
        model_commit();
        if (with_wr != 0) model_wr(idx, fld, data);
        chk("frame_start_pulse", int'(frame_start), 1);
        tick();
        chk("frame_start_clear", int'(frame_start), 0);
    endtask

    task automatic px(int h, int v, int von, int exp, string tag);
        hcount = 10'(h); vcount = 10'(v); video_on = von[0]; px_en = 1'b1;
        tick();
        tick();
        px_en = 1'b0;
        chk(tag, int'(rgb), exp);
    endtask

    initial begin
        int h, v, von, r;
        reset = 1'b1; px_en = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_field = '0; wr_data = '0;
        model_reset();
        tick();
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_frame_start", int'(frame_start), 0);
        tick();
        reset = 1'b0;
        tick();

        px(100, 100, 1, 6, "bg_after_reset");
        px(100, 100, 0, 0, "blank_after_reset");

        wr_rect(0, 255, 18, 125, 125, 1, 1);
        px(300, 50, 1, 6, "shadow_not_visible");
        do_commit(0, 0, 0, 0);
        px(300, 50, 1, 1, "rect0_inside");
        px(380, 50, 1, 6, "rect0_right_edge");
        px(254, 50, 1, 6, "rect0_left_edge");
        px(379, 142, 1, 1, "rect0_bottom_right");
        px(379, 143, 1, 6, "rect0_below");

        wr_rect(0, 230, 178, 180, 125, 1, 1);
        wr_rect(1, 200, 150, 100, 100, 4, 1);
        do_commit(0, 0, 0, 0);
        px(250, 200, 1, 1, "overlap_priority");
        px(210, 160, 1, 4, "rect1_only");

        do_commit(1, 0, 4, 2);
        px(250, 200, 1, 1, "commit_write_deferred");
        do_commit(0, 0, 0, 0);
        px(250, 200, 1, 2, "commit_write_next_frame");

        wr(2, 0, 10); wr(2, 1, 10); wr(2, 3, 50); wr(2, 4, 3); wr(2, 5, 1);
        wr_rect(3, 0, 0, 100, 100, 7, 1);
        do_commit(0, 0, 0, 0);
        px(20, 20, 1, 6, "zero_width_and_bad_idx");

        wr(2, 0, 600); wr(2, 1, 300); wr(2, 2, 100);
        do_commit(0, 0, 0, 0);
        px(600, 310, 1, 3, "clip_left");
        // px_en low: stage 1 and rgb must hold through input changes.
        hcount = 10'd0; video_on = 1'b1;
        tick(); tick(); tick();
        chk("hold_rgb", int'(rgb), 3);
        px_en = 1'b1; tick(); px_en = 1'b0;
        chk("hold_stage1", int'(rgb), 3);
        px(639, 310, 1, 3, "clip_last_col");
        px(599, 310, 1, 6, "clip_before");
        px(0, 310, 1, 6, "no_wrap_col0");
        wr(2, 2, 500);
        do_commit(0, 0, 0, 0);
        px(639, 310, 1, 3, "wide_no_wrap_right");
        px(50, 310, 1, 6, "wide_no_wrap_left");

        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 4; i++) begin
                wr(i, 0, $urandom_range(0, 700));
                wr(i, 1, $urandom_range(0, 520));
                wr(i, 2, $urandom_range(0, 400));
                wr(i, 3, $urandom_range(0, 300));
                wr(i, 4, $urandom_range(0, 1023));
                wr(i, 5, ($urandom_range(0, 3) != 0) ? 1 : 0);
                wr(i, 6, $urandom_range(0, 1));
                wr(i, 7, $urandom_range(0, 1023));
            end
            do_commit(0, 0, 0, 0);
            for (int k = 0; k < 20; k++) begin
                if (k % 2 == 0) begin
                    r = $urandom_range(0, NR - 1);
                    h = (a_x[r] + a_w[r] - int'($urandom_range(0, 1))) % 640;
                    v = (a_y[r] + int'($urandom_range(0, 2))) % 480;
                end else begin
                    h = $urandom_range(0, 639);
                    v = $urandom_range(0, 479);
                end
                von = ($urandom_range(0, 7) != 0) ? 1 : 0;
                px(h, v, von, model_px(h, v, von), "random_pixel");
            end
        end

`ifdef FIG_BLINK_EN
        wr(1, 5, 0); wr(2, 5, 0);
        wr_rect(0, 10, 10, 20, 20, 5, 1);
        wr(0, 6, 1);
        for (int f = 0; f < 6; f++) begin
            do_commit(0, 0, 0, 0);
            px(15, 15, 1, model_px(15, 15, 1), "blink_frame");
            hcount = 10'd500; video_on = 1'b1;
            tick(); tick();
            chk("blink_hold", int'(rgb), model_px(15, 15, 1));
        end
`endif

        reset = 1'b1;
        tick();
        chk("midframe_reset_rgb", int'(rgb), 0);
        reset = 1'b0;
        model_reset();
        px(300, 50, 1, 6, "after_reset_rects_cleared");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
